splitter_6: RTL and testbench

Six-way output splitter. It is the fan-out counterpart to the six-input mixer: it accepts one signed 24-bit mixed sample and produces six independently scaled sends for DAC channels and aux buses. A pre-gain stage is applied first, then six per-channel gains. All gains are ARM-set signed Q4.12. One time-shared multiplier is sequenced by an FSM, and a valid/ready handshake connects to the mixer and DAC side.

---
 rtl/splitter_pkg.sv | 33 +++
 rtl/splitter_6_if.sv | 57 +++++
 rtl/splitter_6_q412_scale_sat.sv | 56 +++++
 rtl/splitter_6.sv | 161 ++++++++++++++++
 tb/tb_splitter_6.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/splitter_pkg.sv
// ---------------------------------------------------------------------------
// splitter_pkg
//   Shared constants and types for the six-way output splitter.
//
//   SAMPLE_W    : sample width (signed)
//   COEFF_W     : coefficient width (signed Q4.12)
//   FRAC_BITS   : fractional bits in a coefficient
//   PROD_W      : full product width
//   NUM_CH      : number of output channels (a..f)
//   SAT_MAX/MIN : saturation limits of a SAMPLE_W signed value
//   COEFF_UNITY : 1.0 in Q4.12
//   state_t     : sequencer states IDLE / PRE / CH / HOLD
// ---------------------------------------------------------------------------
package splitter_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int COEFF_W   = 16;
    localparam int FRAC_BITS = 12;
    localparam int PROD_W    = SAMPLE_W + COEFF_W;
    localparam int NUM_CH    = 6;

    localparam logic [SAMPLE_W-1:0] SAT_MAX     = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN     = 24'h800000;
    localparam logic [COEFF_W-1:0]  COEFF_UNITY = 16'h1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        CH   = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/splitter_6_if.sv
// ---------------------------------------------------------------------------
// splitter_6_if
//   Bus bundle for splitter_6: input handshake, coefficient set, output
//   handshake and the six scaled channel samples.
//
//   Handshake rule (both sides): a beat transfers on a rising clock edge
//   where valid and ready are both high. The sender holds its data and
//   valid until that edge; ready may be deasserted at any time and valid
//   never depends on ready.
//
//   slave  modport : used by splitter_6
//   master modport : used by the sender / sink (mixer, DAC side, bench)
// ---------------------------------------------------------------------------
interface splitter_6_if;
    import splitter_pkg::*;

    logic [SAMPLE_W-1:0] in_sample;
    logic                in_valid;
    logic                in_ready;

    logic [COEFF_W-1:0]  pre_coeff;
    logic [COEFF_W-1:0]  coeff_a;
    logic [COEFF_W-1:0]  coeff_b;
    logic [COEFF_W-1:0]  coeff_c;
    logic [COEFF_W-1:0]  coeff_d;
    logic [COEFF_W-1:0]  coeff_e;
    logic [COEFF_W-1:0]  coeff_f;

    logic [SAMPLE_W-1:0] out_a;
    logic [SAMPLE_W-1:0] out_b;
    logic [SAMPLE_W-1:0] out_c;
    logic [SAMPLE_W-1:0] out_d;
    logic [SAMPLE_W-1:0] out_e;
    logic [SAMPLE_W-1:0] out_f;
    logic                out_valid;
    logic                out_ready;
    logic [6:0]          ovf_flags;

    modport slave (
        input  in_sample, in_valid, pre_coeff,
        input  coeff_a, coeff_b, coeff_c, coeff_d, coeff_e, coeff_f,
        input  out_ready,
        output in_ready,
        output out_a, out_b, out_c, out_d, out_e, out_f,
        output out_valid, ovf_flags
    );

    modport master (
        output in_sample, in_valid, pre_coeff,
        output coeff_a, coeff_b, coeff_c, coeff_d, coeff_e, coeff_f,
        output out_ready,
        input  in_ready,
        input  out_a, out_b, out_c, out_d, out_e, out_f,
        input  out_valid, ovf_flags
    );

endinterface

// File: rtl/splitter_6_q412_scale_sat.sv
// ---------------------------------------------------------------------------
// q412_scale_sat
//   Combinational y = sat24((x * c) >> FRAC_BITS) for a signed sample and a
//   signed Q4.12 coefficient. The shift is arithmetic (floor toward -inf).
//
//   Build option: SPLITTER_ROUND_EN -- when defined, half an LSB of the
//   result (2^(FRAC_BITS-1)) is added to the product before the shift,
//   giving round-half-up instead of floor.
//
//   Ports:
//     x   in  SAMPLE_W  signed sample
//     c   in  COEFF_W   signed Q4.12 coefficient
//     y   out SAMPLE_W  scaled, saturated sample
//     ovf out 1         high when y was clamped
// ---------------------------------------------------------------------------
module q412_scale_sat
    import splitter_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] x,
    input  logic signed [COEFF_W-1:0]  c,
    output logic        [SAMPLE_W-1:0] y,
    output logic                       ovf
);

`ifdef SPLITTER_ROUND_EN
    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(64'd1 << (FRAC_BITS-1));
`else
    localparam logic signed [PROD_W-1:0] ROUND_BIAS = '0;
`endif

    // Limits sign-extended to the product width for a signed compare.
    localparam logic signed [PROD_W-1:0] LIM_HI = PROD_W'(signed'(SAT_MAX));
    localparam logic signed [PROD_W-1:0] LIM_LO = PROD_W'(signed'(SAT_MIN));

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] biased;
    logic signed [PROD_W-1:0] shifted;

    always_comb begin
        // Both operands signed: extended to PROD_W before multiplying.
        // |x*c| <= 2^38 so adding the bias can never wrap.
        prod    = x * c;
        biased  = prod + ROUND_BIAS;
        shifted = biased >>> FRAC_BITS;
        y       = shifted[SAMPLE_W-1:0];
        ovf     = 1'b0;
        if (shifted > LIM_HI) begin
            y   = SAT_MAX;
            ovf = 1'b1;
        end else if (shifted < LIM_LO) begin
            y   = SAT_MIN;
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/splitter_6.sv
// ---------------------------------------------------------------------------
// splitter_6
//   Six-way output splitter. Accepts one signed mixed sample, applies a
//   pre-gain, then six per-channel gains (a..f), all signed Q4.12. One
//   shared q412_scale_sat instance is time-multiplexed by the sequencer:
//     IDLE : in_ready high, waits for a sample
//     PRE  : pre = scale(sample, pre_coeff)
//     CH   : res[idx] = scale(pre, coeff[idx]), idx = 0..5
//     HOLD : first cycle loads outputs and raises out_valid; then waits
//            for out_ready
//   out_valid rises 8 edges after the accept edge.
//
//   Build option: SPLITTER_ROUND_EN (see q412_scale_sat).
//
//   Ports:
//     clk       in  system clock
//     reset     in  synchronous, active-high reset
//     bus       splitter_6_if.slave (samples, coefficients, handshakes,
//               ovf_flags: [6] pre-gain saturated, [5:0] channel f..a)
//     dbg_state out current sequencer state
// ---------------------------------------------------------------------------
module splitter_6
    import splitter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    splitter_6_if.slave       bus,
    output state_t            dbg_state
);

    state_t state;
    logic [2:0] idx;

    // Operands captured at accept; later coefficient writes do not reach
    // the sample in flight.
    logic signed [SAMPLE_W-1:0] samp_r;
    logic signed [COEFF_W-1:0]  pre_c_r;
    logic signed [COEFF_W-1:0]  coef_r [NUM_CH];

    logic signed [SAMPLE_W-1:0] pre_r;
    logic                       pre_ovf_r;
    logic        [SAMPLE_W-1:0] res_r  [NUM_CH];
    logic        [NUM_CH-1:0]   res_ovf_r;

    logic        [SAMPLE_W-1:0] out_r  [NUM_CH];
    logic        [6:0]          ovf_r;
    logic                       out_valid_r;
    logic                       in_ready_r;

    // Shared scaler with its operand mux.
    logic signed [SAMPLE_W-1:0] op_x;
    logic signed [COEFF_W-1:0]  op_c;
    logic        [SAMPLE_W-1:0] sc_y;
    logic                       sc_ovf;

    always_comb begin
        op_x = pre_r;
        op_c = coef_r[0];
        if (state == PRE) begin
            op_x = samp_r;
            op_c = pre_c_r;
        end else begin
            case (idx)
                3'd0:    op_c = coef_r[0];
                3'd1:    op_c = coef_r[1];
                3'd2:    op_c = coef_r[2];
                3'd3:    op_c = coef_r[3];
                3'd4:    op_c = coef_r[4];
                default: op_c = coef_r[5];
            endcase
        end
    end

    q412_scale_sat u_scale (
        .x   (op_x),
        .c   (op_c),
        .y   (sc_y),
        .ovf (sc_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            ovf_r       <= '0;
            samp_r      <= '0;
            pre_c_r     <= '0;
            pre_r       <= '0;
            pre_ovf_r   <= 1'b0;
            res_ovf_r   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                coef_r[i] <= '0;
                res_r[i]  <= '0;
                out_r[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        samp_r     <= bus.in_sample;
                        pre_c_r    <= bus.pre_coeff;
                        coef_r[0]  <= bus.coeff_a;
                        coef_r[1]  <= bus.coeff_b;
                        coef_r[2]  <= bus.coeff_c;
                        coef_r[3]  <= bus.coeff_d;
                        coef_r[4]  <= bus.coeff_e;
                        coef_r[5]  <= bus.coeff_f;
                        in_ready_r <= 1'b0;
                        state      <= PRE;
                    end
                end
                PRE: begin
                    // Channels are scaled from the saturated pre value.
                    pre_r     <= sc_y;
                    pre_ovf_r <= sc_ovf;
                    idx       <= '0;
                    state     <= CH;
                end
                CH: begin
                    res_r[idx]     <= sc_y;
                    res_ovf_r[idx] <= sc_ovf;
                    if (idx == 3'(NUM_CH - 1)) begin
                        state <= HOLD;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                HOLD: begin
                    if (!out_valid_r) begin
                        // Load cycle: all six results and flags move together.
                        for (int i = 0; i < NUM_CH; i++) begin
                            out_r[i] <= res_r[i];
                        end
                        ovf_r       <= {pre_ovf_r, res_ovf_r};
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.ovf_flags = ovf_r;
    assign bus.out_a     = out_r[0];
    assign bus.out_b     = out_r[1];
    assign bus.out_c     = out_r[2];
    assign bus.out_d     = out_r[3];
    assign bus.out_e     = out_r[4];
    assign bus.out_f     = out_r[5];
    assign dbg_state     = state;

endmodule

// File: tb/tb_splitter_6.sv
// ---------------------------------------------------------------------------
// tb_splitter_6
//   Self-checking bench for splitter_6. Expected channel values come from a
//   behavioural model (integer multiply, floor division, clamp) pushed into
//   exp_q on each accept; a monitor pops and compares on every output
//   handshake, and also checks latency, hold stability and in_ready.
// ---------------------------------------------------------------------------
module tb_splitter_6;
    import splitter_pkg::*;

    localparam int EW = 6 * SAMPLE_W + 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    state_t dbg_state;
    always #5 clk = ~clk;

    splitter_6_if bus();

    splitter_6 dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            rdy_mode = 0;   // 0: ready high, 1: random, 2: held low
    bit            prev_valid = 1'b0;
    logic [EW-1:0] snap;
    logic [EW-1:0] cur;

    assign cur = {bus.ovf_flags, bus.out_f, bus.out_e, bus.out_d,
                  bus.out_c, bus.out_b, bus.out_a};

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {ovf, y}: y = clamp(floor(x*c / 4096)), optionally rounded.
    function automatic logic [SAMPLE_W:0] scale_ref(input longint x, input longint c);
        longint p;
        longint q;
        logic [SAMPLE_W:0] r;
        p = x * c;
`ifdef SPLITTER_ROUND_EN
        p = p + 2048;
`endif
        q = p / 4096;
        if ((p % 4096 != 0) && (p < 0)) q = q - 1;
        r[SAMPLE_W] = 1'b0;
        if (q > 8388607) begin
            q = 8388607;
            r[SAMPLE_W] = 1'b1;
        end else if (q < -8388608) begin
            q = -8388608;
            r[SAMPLE_W] = 1'b1;
        end
        r[SAMPLE_W-1:0] = q[SAMPLE_W-1:0];
        return r;
    endfunction

    function automatic logic [EW-1:0] model(input logic [23:0] s, input logic [15:0] pc,
                                            input logic [95:0] cs);
        logic [SAMPLE_W:0] r;
        logic [SAMPLE_W:0] rc;
        logic [15:0]       c;
        longint            pre;
        logic [EW-1:0]     e;
        e = '0;
        r = scale_ref(longint'($signed(s)), longint'($signed(pc)));
        e[EW-1] = r[SAMPLE_W];
        pre = longint'($signed(r[SAMPLE_W-1:0]));
        for (int i = 0; i < 6; i++) begin
            c = cs[16*i +: 16];
            rc = scale_ref(pre, longint'($signed(c)));
            e[24*i +: 24] = rc[SAMPLE_W-1:0];
            e[144 + i]    = rc[SAMPLE_W];
        end
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [23:0] s, input logic [15:0] pc, input logic [95:0] cs);
        bit done;
        done = 1'b0;
        bus.in_sample = s;
        bus.pre_coeff = pc;
        {bus.coeff_f, bus.coeff_e, bus.coeff_d, bus.coeff_c, bus.coeff_b, bus.coeff_a} = cs;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready && !reset) begin
                exp_q.push_back(model(s, pc, cs));
                acc_q.push_back(cyc + 1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready=1 (cycle %0d)", cyc);
        end
    endtask

    task automatic scramble();
        bus.in_sample = 24'($urandom);
        bus.pre_coeff = 16'($urandom);
        {bus.coeff_f, bus.coeff_e, bus.coeff_d} = 48'({$urandom, $urandom});
        {bus.coeff_c, bus.coeff_b, bus.coeff_a} = 48'({$urandom, $urandom});
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.out_valid && bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", EW'(bus.out_valid), '0);
        chk("rst_in_ready", EW'(bus.in_ready), '0);
        chk("rst_outputs", cur, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", EW'(bus.in_ready), EW'(1));
        chk("post_rst_out_valid", EW'(bus.out_valid), '0);
        chk("post_rst_outputs", cur, '0);
    endtask

    function automatic logic [15:0] pick_c();
        case ($urandom_range(0, 7))
            0: return 16'h1000;
            1: return 16'h0800;
            2: return 16'h2000;
            3: return 16'hF000;
            4: return 16'h0000;
            5: return 16'h7FFF;
            6: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [23:0] pick_s();
        case ($urandom_range(0, 5))
            0: return 24'h7FFFFF;
            1: return 24'h800000;
            2: return 24'hFFFFFF;
            3: return 24'h000000;
            default: return 24'($urandom);
        endcase
    endfunction

    // ---------------- out_ready generator ----------------
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (!prev_valid) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_out_valid", EW'(1), '0);
                    end else begin
                        chk("latency", EW'(cyc - acc_q.pop_front()), EW'(8));
                    end
                end else begin
                    chk("hold_stable", cur, snap);
                end
                chk("in_ready_busy", EW'(bus.in_ready), '0);
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_output", EW'(1), '0);
                    end else begin
                        logic [EW-1:0] e;
                        e = exp_q.pop_front();
                        chk("out_a", EW'(bus.out_a), EW'(e[0 +: 24]));
                        chk("out_b", EW'(bus.out_b), EW'(e[24 +: 24]));
                        chk("out_c", EW'(bus.out_c), EW'(e[48 +: 24]));
                        chk("out_d", EW'(bus.out_d), EW'(e[72 +: 24]));
                        chk("out_e", EW'(bus.out_e), EW'(e[96 +: 24]));
                        chk("out_f", EW'(bus.out_f), EW'(e[120 +: 24]));
                        chk("ovf_flags", EW'(bus.ovf_flags), EW'(e[144 +: 7]));
                    end
                end
            end
            prev_valid = bus.out_valid;
            snap       = cur;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        bus.in_valid = 1'b0;
        scramble();
        do_reset();

        // Basic gains.
        rdy_mode = 0;
        send(24'h100000, 16'h1000, {16'h7FFF, 16'h0000, 16'hF000, 16'h2000, 16'h0800, 16'h1000});
        wait_idle();

        // Saturation: pre clamps, channel c clamps.
        send(24'h7FFFFF, 16'h7FFF, {16'h1000, 16'h0800, 16'h1000, 16'h2000, 16'h1000, 16'h1000});
        wait_idle();
        // Negative full-scale times -1.0 clamps on channel d.
        send(24'h800000, 16'h1000, {16'h1000, 16'h1000, 16'hF000, 16'h1000, 16'h1000, 16'h1000});
        wait_idle();

        // Rounding of -1 LSB * 0.5.
        send(24'hFFFFFF, 16'h1000, {16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0800});
        wait_idle();

        // Backpressure with a competing sample held on the input.
        rdy_mode = 2;
        send(24'h123456, 16'h0C00, {16'h1000, 16'h0400, 16'hE000, 16'h1800, 16'h1000, 16'h3000});
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("bp_out_valid_seen", EW'(seen), EW'(1));
        for (int t = 0; t < 20; t++) begin
            bus.in_valid  = 1'b1;
            bus.in_sample = 24'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid) seen = 1'b1;
        end
        chk("bp_handshake_done", EW'(seen), EW'(1));
        chk("bp_in_ready_after", EW'(bus.in_ready), EW'(1));
        wait_idle();

        // Coefficient isolation: coeff_b changes after accept.
        send(24'h0A0B0C, 16'h1000, {16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000});
        repeat (2) @(posedge clk);
        #1;
        bus.coeff_b = 16'h0000;
        bus.pre_coeff = 16'h0000;
        wait_idle();

        // Reset in the middle of the channel stage.
        send(24'h200000, 16'h1000, {16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000});
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        repeat (15) @(posedge clk);
        #1;
        chk("no_stale_valid", EW'(bus.out_valid), '0);

        // Randomized traffic with random backpressure and input churn.
        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            send(pick_s(), pick_c(),
                 {pick_c(), pick_c(), pick_c(), pick_c(), pick_c(), pick_c()});
            scramble();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
